// File: rtl/memory_bus_pkg.sv
// rtl/memory_bus_pkg.sv - shared address map, status bit positions and UART state encoding
package memory_bus_pkg;

    localparam logic [31:0] RAM_BASE         = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK         = 32'hF000_0000;
    localparam logic [31:0] UART_DATA_ADDR   = 32'h1000_0000;
    localparam logic [31:0] UART_STATUS_ADDR = 32'h1000_0004;
    localparam logic [31:0] LED_ADDR         = 32'h1000_0008;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_EMPTY_BIT = 2;
    localparam int STATUS_OVF_BIT   = 3;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // Word-granular address compare: the byte offset bits never take part in decode.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/memory_bus_if.sv
// rtl/memory_bus_if.sv - core-side load/store bus between the RV32I core and the memory stage
interface memory_bus_if;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (output mem_write, output address, output write_data, input  read_data);
    modport slave  (input  mem_write, input  address, input  write_data, output read_data);
endinterface

// File: rtl/memory_bus_uart_tx.sv
// rtl/memory_bus_uart_tx.sv - 8N1 UART transmitter fed by a byte valid/ready handshake
module memory_bus_uart_tx
    import memory_bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tdata_i,
    input  logic       tvalid_i,
    output logic       tready_o,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          baud_last;

    assign baud_last = (baud_q == BAUD_LAST);
    assign tready_o  = (state_q == UART_IDLE);
    assign busy_o    = (state_q != UART_IDLE);
    assign tx_o      = tx_q;

    // Next-state logic: walk START, eight DATA bits LSB first, STOP, each CLKS_PER_BIT long.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            UART_IDLE: begin
                if (tvalid_i) begin
                    shift_d = tdata_i;
                    baud_d  = '0;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = UART_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            UART_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            UART_STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = UART_IDLE;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    // Line level follows the current state one cycle later so tx comes straight off a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            UART_START: tx_d = 1'b0;
            UART_DATA:  tx_d = shift_q[0];
            default:    tx_d = 1'b1;
        endcase
    end

    // State register; reset abandons any frame in flight and parks the line high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/memory_bus.sv
// rtl/memory_bus.sv - data memory stage: word RAM, LED register and UART TX with FIFO
module memory_bus
    import memory_bus_pkg::*;
#(
    parameter int RAM_WORDS  = 256,
    parameter int CLOCK_HZ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    memory_bus_if.slave  bus,
    output logic [7:0]   leds,
    output logic         tx
);

    localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD;
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0]   ram_q [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    leds_q, leds_d;

    logic          in_ram, hit_uart_data, hit_status, hit_led;
    logic [AW-1:0] ram_idx;
    logic          full, empty, push_req, push, pop, tready, busy;
    logic [31:0]   status_word;
    logic          unused_addr_bits;

    assign in_ram        = (bus.address & RAM_MASK) == RAM_BASE;
    assign hit_uart_data = word_match(bus.address, UART_DATA_ADDR);
    assign hit_status    = word_match(bus.address, UART_STATUS_ADDR);
    assign hit_led       = word_match(bus.address, LED_ADDR);
    assign ram_idx       = bus.address[AW+1:2];
    assign unused_addr_bits = ^bus.address[1:0];

    assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push_req = bus.mem_write && hit_uart_data;
    assign pop      = !empty && tready;
    // A full FIFO still accepts a byte when the transmitter frees a slot in the same cycle.
    assign push     = push_req && (!full || pop);
    assign leds     = leds_q;

    // Status word assembled from live FIFO/FSM state.
    always_comb begin
        status_word = '0;
        status_word[STATUS_BUSY_BIT]  = busy;
        status_word[STATUS_FULL_BIT]  = full;
        status_word[STATUS_EMPTY_BIT] = empty;
        status_word[STATUS_OVF_BIT]   = overflow_q;
    end

    // Zero-latency load path for the single-cycle core.
    always_comb begin
        bus.read_data = '0;
        if (in_ram) begin
            bus.read_data = ram_q[ram_idx];
        end else if (hit_status) begin
            bus.read_data = status_word;
        end else if (hit_led) begin
            bus.read_data = {24'b0, leds_q};
        end
    end

    // FIFO pointers, occupancy, sticky overflow and LED register next state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        leds_d     = leds_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        if (bus.mem_write && hit_status) begin
            overflow_d = 1'b0;
        end else if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (bus.mem_write && hit_led) leds_d = bus.write_data[7:0];
    end

    // Control registers; reset flushes the FIFO by clearing pointers and count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            leds_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            leds_q     <= leds_d;
        end
    end

    // Storage arrays carry no reset; stale FIFO slots are unreachable once pointers clear.
    always_ff @(posedge clock) begin
        if (bus.mem_write && in_ram) ram_q[ram_idx] <= bus.write_data;
        if (push) fifo_q[wr_ptr_q] <= bus.write_data[7:0];
    end

    memory_bus_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clock    (clock),
        .reset    (reset),
        .tdata_i  (fifo_q[rd_ptr_q]),
        .tvalid_i (!empty),
        .tready_o (tready),
        .busy_o   (busy),
        .tx_o     (tx)
    );

endmodule

// File: tb/tb_memory_bus.sv
// tb/tb_memory_bus.sv - self-checking bench for memory_bus
module tb_memory_bus;
    import memory_bus_pkg::*;

    localparam int CPB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] leds;
    logic       tx;

    memory_bus_if bus();

    memory_bus #(
        .RAM_WORDS  (256),
        .CLOCK_HZ   (4),
        .BAUD       (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .leds  (leds),
        .tx    (tx)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bus.mem_write  = we;
        bus.address    = addr;
        bus.write_data = data;
    endtask

    // Reference model: plain arrays for RAM and the LED byte, decoded from the address map.
    logic [31:0] ram_m [256];
    bit          ram_v [256];
    logic [7:0]  leds_m = 8'h00;

    task automatic model_read(input logic [31:0] a, output bit known, output logic [31:0] val);
        known = 1'b1;
        val   = 32'h0;
        if (a[31:28] == 4'h0) begin
            known = ram_v[a[9:2]];
            val   = ram_m[a[9:2]];
        end else if (a[31:2] == LED_ADDR[31:2]) begin
            val = {24'h0, leds_m};
        end else if (a[31:2] == UART_STATUS_ADDR[31:2]) begin
            known = 1'b0;
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (a[31:28] == 4'h0) begin
            ram_m[a[9:2]] = d;
            ram_v[a[9:2]] = 1'b1;
        end else if (a[31:2] == LED_ADDR[31:2]) begin
            leds_m = d[7:0];
        end
    endtask

    // Serial receiver sampling mid-bit; collects decoded bytes.
    logic [7:0] rx_q [$];
    bit         rx_busy = 1'b0;
    int         rx_cnt  = 0;
    logic [7:0] rx_byte = 8'h00;

    always @(posedge clock) begin
        #1;
        if (!reset) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt > CPB && rx_cnt < 9*CPB && (rx_cnt % CPB) == CPB/2) begin
                rx_byte[(rx_cnt - CPB - CPB/2) / CPB] = tx;
            end else if (rx_cnt == 9*CPB + CPB/2) begin
                check("rx_stop_bit", 32'(tx), 32'h1);
                rx_q.push_back(rx_byte);
                rx_busy = 1'b0;
            end
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_leds;
    } vec_t;

    vec_t vecs [$];

    task automatic add_vec(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic c, input logic [31:0] e, input logic [7:0] l);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = d; v.chk_rd = c; v.exp_rd = e; v.exp_leds = l;
        vecs.push_back(v);
    endtask

    initial begin
        bit          known;
        logic [31:0] mval;
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic [7:0]  b;
        int          kind;
        int          guard;
        int          lows;
        logic        exp_tx;
        int          pos;

        foreach (ram_v[i]) ram_v[i] = 1'b0;

        add_vec(1, 32'h0000_0010, 32'hDEADBEEF, 0, 32'h0,        8'h00);
        add_vec(0, 32'h0000_0010, 32'h0,        1, 32'hDEADBEEF, 8'h00);
        add_vec(1, 32'h0000_0014, 32'h11111111, 0, 32'h0,        8'h00);
        add_vec(0, 32'h0000_0010, 32'h0,        1, 32'hDEADBEEF, 8'h00);
        add_vec(0, 32'h0000_0014, 32'h0,        1, 32'h11111111, 8'h00);
        add_vec(1, 32'h0000_0010, 32'hCAFEF00D, 1, 32'hDEADBEEF, 8'h00);
        add_vec(0, 32'h0000_0013, 32'h0,        1, 32'hCAFEF00D, 8'h00);
        add_vec(0, 32'h0000_0410, 32'h0,        1, 32'hCAFEF00D, 8'h00);
        add_vec(0, 32'h2000_0000, 32'h0,        1, 32'h0,        8'h00);
        add_vec(1, 32'h2000_0010, 32'h12345678, 1, 32'h0,        8'h00);
        add_vec(0, 32'h0000_0010, 32'h0,        1, 32'hCAFEF00D, 8'h00);
        add_vec(1, 32'h1000_0008, 32'h123456A5, 1, 32'h0,        8'hA5);
        add_vec(0, 32'h1000_0008, 32'h0,        1, 32'h000000A5, 8'hA5);
        add_vec(0, 32'h1000_000A, 32'h0,        1, 32'h000000A5, 8'hA5);
        add_vec(0, 32'h1000_0000, 32'h0,        1, 32'h0,        8'hA5);
        add_vec(0, 32'h1000_000C, 32'h0,        1, 32'h0,        8'hA5);
        add_vec(0, 32'h1000_0004, 32'h0,        1, 32'h4,        8'hA5);

        // Reset for two edges, then release.
        drive(1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        bus.address = UART_STATUS_ADDR;
        #1;
        check("reset_tx", 32'(tx), 32'h1);
        check("reset_leds", 32'(leds), 32'h0);
        check("reset_status", bus.read_data, 32'h4);

        // Directed vectors.
        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            #1;
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), bus.read_data, vecs[i].exp_rd);
            tick();
            if (vecs[i].we) model_write(vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
        end

        // Randomised RAM / LED / unmapped traffic against the model.
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 3));
            a    = $urandom;
            d    = $urandom;
            we   = 1'($urandom_range(0, 1));
            case (kind)
                0: begin a[31:28] = 4'h0; a[9:6] = 4'h0; end
                1: a = LED_ADDR | 32'($urandom_range(0, 3));
                2: if (a[31:28] == 4'h0 || a[31:4] == 28'h1000_000) a[31:28] = 4'h3;
                default: begin a = UART_DATA_ADDR; we = 1'b0; end
            endcase
            drive(we, a, d);
            #1;
            model_read(a, known, mval);
            if (known) check($sformatf("rand%0d_rd", n), bus.read_data, mval);
            tick();
            if (we) model_write(a, d);
            check($sformatf("rand%0d_leds", n), 32'(leds), 32'(leds_m));
        end

        // Single frame of 0x55, checked cycle by cycle against the 8N1 waveform.
        drive(1'b0, UART_STATUS_ADDR, 32'h0);
        tick();
        rx_q.delete();
        b = 8'h55;
        drive(1'b1, UART_DATA_ADDR, 32'(b));
        tick();
        drive(1'b0, UART_STATUS_ADDR, 32'h0);
        for (int k = 1; k <= 44; k++) begin
            tick();
            exp_tx = 1'b1;
            if (k >= 2 && k < 2 + 10*CPB) begin
                pos = (k - 2) / CPB;
                if (pos == 0)      exp_tx = 1'b0;
                else if (pos == 9) exp_tx = 1'b1;
                else               exp_tx = b[pos-1];
            end
            check($sformatf("frame_tx_k%0d", k), 32'(tx), 32'(exp_tx));
            check($sformatf("frame_busy_k%0d", k), 32'(bus.read_data[STATUS_BUSY_BIT]),
                  (k >= 1 && k <= 10*CPB) ? 32'h1 : 32'h0);
        end
        check("frame_rx_count", 32'(rx_q.size()), 32'h1);
        if (rx_q.size() > 0) check("frame_rx_byte", 32'(rx_q[0]), 32'h55);
        check("frame_status_idle", bus.read_data, 32'h4);

        // Overflow: six back-to-back pushes into a depth-4 FIFO.
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, UART_DATA_ADDR, 32'hA1 + 32'(i));
            tick();
        end
        drive(1'b0, UART_STATUS_ADDR, 32'h0);
        #1;
        check("ovf_status", bus.read_data, 32'hB);
        drive(1'b1, UART_STATUS_ADDR, 32'hFFFF_FFFF);
        tick();
        drive(1'b0, UART_STATUS_ADDR, 32'h0);
        #1;
        check("ovf_cleared_status", bus.read_data, 32'h3);
        guard = 0;
        while (rx_q.size() < 5 && guard < 400) begin
            tick();
            guard++;
        end
        check("ovf_rx_count", 32'(rx_q.size()), 32'h5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) check($sformatf("ovf_rx_byte%0d", i), 32'(rx_q[i]), 32'hA1 + 32'(i));
        end
        repeat (8) tick();
        check("ovf_drained_status", bus.read_data, 32'h4);
        check("ovf_no_extra_byte", 32'(rx_q.size()), 32'h5);

        // Reset in the middle of the DATA bits.
        rx_q.delete();
        drive(1'b1, UART_DATA_ADDR, 32'h0F);
        tick();
        drive(1'b0, UART_STATUS_ADDR, 32'h0);
        repeat (12) tick();
        reset = 1'b0;
        tick();
        check("midreset_tx", 32'(tx), 32'h1);
        check("midreset_status", bus.read_data, 32'h4);
        leds_m = 8'h00;
        check("midreset_leds", 32'(leds), 32'h0);
        reset = 1'b1;
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check("midreset_tx_stays_high", 32'(lows), 32'h0);
        check("midreset_no_frame", 32'(rx_q.size()), 32'h0);
        check("midreset_status_after", bus.read_data, 32'h4);
        for (int w = 0; w < 16; w++) begin
            a = 32'(w) << 2;
            drive(1'b0, a, 32'h0);
            #1;
            model_read(a, known, mval);
            if (known) check($sformatf("ram_kept_w%0d", w), bus.read_data, mval);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
